// File: rtl/dpi_stream_sequencer.sv
// Packet-to-stream sequencer: maps each packet's flow tag to a 64-slot stream id,
// pulses a state-restore strobe, then replays the bytes to the matcher and closes with eop.
module dpi_stream_sequencer #(
  parameter int LOAD_GAP   = 2,
  parameter int EOP_DELAY  = 3,
  parameter bit EN_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_vld,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  input  logic [7:0]  pkt_data,
  input  logic [15:0] pkt_flow_id,
  output logic        pkt_rdy,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_sid,
  input  logic        cfg_en,
  output logic        load_state,
  output logic        new_stream_id,
  output logic [5:0]  stream_id,
  output logic [7:0]  char_in,
  output logic        char_in_vld,
  output logic        eop,
  output logic        enable,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;

  localparam int GAP_LAST   = LOAD_GAP - 1;
  localparam int DRAIN_LAST = EOP_DELAY - 2;

  state_t      state, next_state;
  logic [15:0] dly_cnt;
  logic [15:0] tag_mem [64];
  logic [63:0] tag_vld;
  logic [63:0] en_table;
  logic [5:0]  alloc_ptr;
  logic [15:0] hold_flow;
  logic [7:0]  hold_data;
  logic        hold_eop;
  logic        last_seen;
  logic        en_q;
  logic        hit;
  logic [5:0]  hit_idx;
  logic        accept;
  logic        allocate;
  logic        err_inc;

  // Once the eop byte sits on char_in nothing more may be taken for this packet
  assign pkt_rdy     = rst_n && ((state == IDLE) || ((state == STREAM) && !last_seen));
  assign accept      = pkt_vld && pkt_rdy;
  assign load_state  = (state == LOAD);
  assign eop         = (state == EOP);
  assign enable      = (state == LOAD) ? en_table[stream_id] : en_q;
  assign allocate    = (state == LOOKUP) && !hit;
  assign err_inc     = accept && (((state == IDLE) && !pkt_sop) || ((state == STREAM) && pkt_sop));

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (!hit && tag_vld[i] && (tag_mem[i] == hold_flow)) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && pkt_sop) next_state = LOOKUP;
      LOOKUP:  next_state = LOAD;
      LOAD:    next_state = (LOAD_GAP == 0) ? STREAM : GAP;
      GAP:     if (int'(dly_cnt) >= GAP_LAST) next_state = STREAM;
      STREAM:  if (last_seen) next_state = (EOP_DELAY <= 1) ? EOP : DRAIN;
      DRAIN:   if (int'(dly_cnt) >= DRAIN_LAST) next_state = EOP;
      EOP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // dly_cnt restarts on every state change and counts cycles spent in GAP/DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dly_cnt <= '0;
    end else begin
      state   <= next_state;
      dly_cnt <= (next_state != state) ? '0 : dly_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld   <= '0;
      alloc_ptr <= '0;
    end else if (allocate) begin
      tag_vld[alloc_ptr] <= 1'b1;
      alloc_ptr          <= alloc_ptr + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (allocate) tag_mem[alloc_ptr] <= hold_flow;
  end

  // A same-cycle cfg write overrides the default of a freshly allocated slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_table <= {64{EN_DEFAULT}};
    end else begin
      if (allocate) en_table[alloc_ptr] <= EN_DEFAULT;
      if (cfg_wr)   en_table[cfg_sid]   <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_flow     <= '0;
      hold_data     <= '0;
      hold_eop      <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      en_q          <= 1'b0;
    end else begin
      if ((state == IDLE) && accept && pkt_sop) begin
        hold_flow <= pkt_flow_id;
        hold_data <= pkt_data;
        hold_eop  <= pkt_eop;
      end
      if (state == LOOKUP) begin
        stream_id     <= hit ? hit_idx : alloc_ptr;
        new_stream_id <= !hit;
      end
      if (state == LOAD) en_q <= en_table[stream_id];
    end
  end

  // The held SOP byte is launched on the edge into STREAM; later beats follow one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_in     <= '0;
      char_in_vld <= 1'b0;
      last_seen   <= 1'b0;
    end else if ((state != STREAM) && (next_state == STREAM)) begin
      char_in     <= hold_data;
      char_in_vld <= 1'b1;
      last_seen   <= hold_eop;
    end else if ((state == STREAM) && accept) begin
      char_in     <= pkt_data;
      char_in_vld <= 1'b1;
      last_seen   <= pkt_eop;
    end else begin
      char_in_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: packet timing, tag hits/misses, table wrap,
// protocol errors, enable freezing and mid-packet reset.
module tb_dpi_stream_sequencer;

  localparam int LOAD_GAP  = 2;
  localparam int EOP_DELAY = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_vld, pkt_sop, pkt_eop;
  logic [7:0]  pkt_data;
  logic [15:0] pkt_flow_id;
  logic        pkt_rdy;
  logic        cfg_wr;
  logic [5:0]  cfg_sid;
  logic        cfg_en;
  logic        load_state, new_stream_id;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic        char_in_vld, eop, enable;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(.LOAD_GAP(LOAD_GAP), .EOP_DELAY(EOP_DELAY), .EN_DEFAULT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_data(pkt_data), .pkt_flow_id(pkt_flow_id), .pkt_rdy(pkt_rdy),
    .cfg_wr(cfg_wr), .cfg_sid(cfg_sid), .cfg_en(cfg_en),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .enable(enable),
    .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge
  int         ld_count = 0, ld_cyc = 0, eop_count = 0, eop_cyc = 0;
  int         ch_n = 0, unstable = 0, overlap = 0;
  logic [5:0] ld_sid = '0;
  logic       ld_new = 1'b0, ld_en = 1'b0, eop_en = 1'b0, in_pkt = 1'b0;
  logic [7:0] ch_mem [1024];
  int         chc_mem [1024];

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt <= 1'b0;
    end else begin
      if (load_state) begin
        ld_count <= ld_count + 1;
        ld_cyc   <= cyc;
        ld_sid   <= stream_id;
        ld_new   <= new_stream_id;
        ld_en    <= enable;
        in_pkt   <= 1'b1;
      end else if (in_pkt && ((stream_id !== ld_sid) || (enable !== ld_en))) begin
        unstable <= unstable + 1;
      end
      if (eop) begin
        eop_count <= eop_count + 1;
        eop_cyc   <= cyc;
        eop_en    <= enable;
        in_pkt    <= 1'b0;
      end
    end
    if (char_in_vld) begin
      ch_mem[ch_n % 1024]  <= char_in;
      chc_mem[ch_n % 1024] <= cyc;
      ch_n                 <= ch_n + 1;
    end
    if (load_state && eop) overlap <= overlap + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one beat and hold it until accepted; acc is the cycle index of acceptance
  task automatic applyStimulus(input logic s, input logic e, input logic [7:0] d,
                               input logic [15:0] f, output int acc);
    pkt_vld = 1'b1; pkt_sop = s; pkt_eop = e; pkt_data = d; pkt_flow_id = f;
    acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge clk);
      if (pkt_rdy) acc = cyc;
      @(posedge clk); #1;
    end
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    checkOutput("beat_accept", 32'(acc >= 0), 1);
  endtask

  int sop_acc, base_ch, base_ld, base_eop, tail_rdy;
  logic eop_done;

  task automatic runPacket(input logic [15:0] flow, input int n, input logic [63:0] bytes,
                           input logic [7:0] sopx);
    int acc;
    base_ch = ch_n; base_ld = ld_count; base_eop = eop_count;
    for (int i = 0; i < n; i++) begin
      applyStimulus((i == 0) || sopx[i], i == n - 1, bytes[8*i +: 8], flow, acc);
      if (i == 0) sop_acc = acc;
    end
    tail_rdy = 0; eop_done = 1'b0;
    for (int k = 0; k < 40 && !eop_done; k++) begin
      @(negedge clk);
      if (pkt_rdy) tail_rdy++;
      #1;
      if (eop_count != base_eop) eop_done = 1'b1;
    end
    checkOutput("eop_seen", 32'(eop_done), 1);
    @(posedge clk); #1;
  endtask

  task automatic verifyPacket(input int es, input logic en_new, input logic een,
                              input int n, input logic [63:0] bytes);
    checkOutput("load_count", ld_count - base_ld, 1);
    checkOutput("load_cycle", ld_cyc - sop_acc, 2);
    checkOutput("stream_id", 32'(ld_sid), es);
    checkOutput("new_stream_id", 32'(ld_new), 32'(en_new));
    checkOutput("enable_load", 32'(ld_en), 32'(een));
    checkOutput("enable_eop", 32'(eop_en), 32'(een));
    checkOutput("char_count", ch_n - base_ch, n);
    for (int i = 0; i < n; i++) begin
      checkOutput("char_data", 32'(ch_mem[(base_ch + i) % 1024]), 32'(bytes[8*i +: 8]));
      checkOutput("char_cycle", chc_mem[(base_ch + i) % 1024] - ld_cyc, LOAD_GAP + 1 + i);
    end
    checkOutput("eop_cycle", eop_cyc - chc_mem[(base_ch + n - 1) % 1024], EOP_DELAY);
    checkOutput("tail_rdy", tail_rdy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, b0, b1, b2;
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = '0; pkt_flow_id = '0;
    cfg_wr = 1'b0; cfg_sid = '0; cfg_en = 1'b0;
    #2;
    checkOutput("rst_pkt_rdy", 32'(pkt_rdy), 0);
    checkOutput("rst_load_state", 32'(load_state), 0);
    checkOutput("rst_char_vld", 32'(char_in_vld), 0);
    checkOutput("rst_eop", 32'(eop), 0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("rst_enable", 32'(enable), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_release", 32'(pkt_rdy), 1);
    @(posedge clk); #1;

    // Fresh flow, new flow, then repeat of the first flow as a single-byte packet
    runPacket(16'h1234, 4, {32'h0, "dcba"}, 8'h00);
    verifyPacket(0, 1'b1, 1'b1, 4, {32'h0, "dcba"});
    runPacket(16'h5678, 2, {48'h0, "yx"}, 8'h00);
    verifyPacket(1, 1'b1, 1'b1, 2, {48'h0, "yx"});
    runPacket(16'h1234, 1, {56'h0, "z"}, 8'h00);
    verifyPacket(0, 1'b0, 1'b1, 1, {56'h0, "z"});

    // Non-SOP beat while idle is dropped and counted
    b0 = ch_n; b1 = ld_count;
    applyStimulus(1'b0, 1'b0, "q", 16'h9999, acc);
    repeat (6) @(posedge clk); #1;
    checkOutput("idle_err_cnt", 32'(err_cnt), 1);
    checkOutput("idle_drop_chars", ch_n - b0, 0);
    checkOutput("idle_drop_load", ld_count - b1, 0);

    // SOP inside a packet passes as data; disabling stream 0 mid-packet must not reach enable yet
    fork
      runPacket(16'h1234, 3, {40'h0, "onm"}, 8'b0000_0010);
      begin : cfg_branch
        b2 = ld_count;
        for (int k = 0; k < 40 && ld_count == b2; k++) begin
          @(negedge clk); #1;
        end
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_sid = 6'd0; cfg_en = 1'b0;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
      end
    join
    verifyPacket(0, 1'b0, 1'b1, 3, {40'h0, "onm"});
    checkOutput("sop_in_pkt_err_cnt", 32'(err_cnt), 2);
    runPacket(16'h1234, 2, {48'h0, "ts"}, 8'h00);
    verifyPacket(0, 1'b0, 1'b0, 2, {48'h0, "ts"});

    // Reset in the middle of a streaming packet
    b0 = ch_n;
    applyStimulus(1'b1, 1'b0, "r", 16'hABCD, acc);
    pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = "s";
    for (int k = 0; k < 20 && ch_n == b0; k++) begin
      @(negedge clk); #1;
    end
    checkOutput("reach_stream", ch_n - b0, 1);
    checkOutput("pre_rst_stream_id", 32'(stream_id), 2);
    rst_n = 1'b0; pkt_vld = 1'b0;
    b1 = eop_count;
    #1;
    checkOutput("mid_rst_char_vld", 32'(char_in_vld), 0);
    checkOutput("mid_rst_char_in", 32'(char_in), 0);
    checkOutput("mid_rst_stream_id", 32'(stream_id), 0);
    checkOutput("mid_rst_new_id", 32'(new_stream_id), 0);
    checkOutput("mid_rst_load", 32'(load_state), 0);
    checkOutput("mid_rst_eop", 32'(eop), 0);
    checkOutput("mid_rst_rdy", 32'(pkt_rdy), 0);
    checkOutput("mid_rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("mid_rst_enable", 32'(enable), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    checkOutput("no_eop_after_rst", eop_count - b1, 0);
    runPacket(16'h1234, 2, {48'h0, "vu"}, 8'h00);
    verifyPacket(0, 1'b1, 1'b1, 2, {48'h0, "vu"});

    // Table wrap: 65 distinct flows from a clean table
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 65; i++) begin
      runPacket(16'h1000 + 16'(i), 1, {56'h0, 8'(i)}, 8'h00);
      verifyPacket(i % 64, 1'b1, 1'b1, 1, {56'h0, 8'(i)});
    end
    runPacket(16'h1040, 1, {56'h0, "h"}, 8'h00);
    verifyPacket(0, 1'b0, 1'b1, 1, {56'h0, "h"});
    runPacket(16'h1000, 1, {56'h0, "w"}, 8'h00);
    verifyPacket(1, 1'b1, 1'b1, 1, {56'h0, "w"});

    checkOutput("id_enable_stable", unstable, 0);
    checkOutput("load_eop_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
